// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared constants for the multi-cycle MIPS control path.
//             It holds the opcodes, the ALUOp codes, the mux select codes,
//             the FSM state encoding and the decoded control-word layout.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

   // IR[31:26] opcodes understood by the main control
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ALUOp codes consumed by the ALU control decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU operand-B select
   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // FSM state encoding (13..15 are unused)
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_WB_MEM   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_WB_ALU   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   // Decoded control word
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_control_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_decode
//  Purpose  : Purely combinational decode of FSM state (and mem_ready where
//             a state waits on memory) into the datapath control word.
//  Ports    : i_state     in  4   current FSM state
//             i_mem_ready in  1   memory handshake
//             o_ctrl      out     decoded control word (ctrl_t)
//  Config   : MC_CONTROL_ADDI_EN enables decode of the ADDI_EX/ADDI_WB states;
//             without it those encodings decode to all zeros.
//  Revision : 1.0  initial release
// ============================================================================
module mc_control_decode
   import mips_pkg::*;
(
   input  state_t i_state,
   input  logic   i_mem_ready,
   output ctrl_t  o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.alu_src_b = SRCB_FOUR;
            o_ctrl.alu_op    = ALUOP_ADD;
            o_ctrl.pc_source = PCSRC_ALU;
            // IR load and PC+4 commit only when the fetch read completes
            o_ctrl.ir_write  = i_mem_ready;
            o_ctrl.pc_write  = i_mem_ready;
         end
         S_DECODE: begin
            // Precompute the branch target while the opcode is decoded
            o_ctrl.alu_src_b = SRCB_IMM_SH2;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_ADDR: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.i_or_d   = 1'b1;
         end
         S_WB_MEM: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_MEM_WR: begin
            o_ctrl.mem_write  = 1'b1;
            o_ctrl.i_or_d     = 1'b1;
            o_ctrl.instr_done = i_mem_ready;
         end
         S_EXEC: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_REGB;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_WB_ALU: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.reg_dst    = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            o_ctrl.alu_src_a     = 1'b1;
            o_ctrl.alu_src_b     = SRCB_REGB;
            o_ctrl.alu_op        = ALUOP_SUB;
            o_ctrl.pc_write_cond = 1'b1;
            o_ctrl.pc_source     = PCSRC_ALUOUT;
            o_ctrl.instr_done    = 1'b1;
         end
         S_JUMP: begin
            o_ctrl.pc_write   = 1'b1;
            o_ctrl.pc_source  = PCSRC_JUMP;
            o_ctrl.instr_done = 1'b1;
         end
`ifdef MC_CONTROL_ADDI_EN
         S_ADDI_EX: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         S_ADDI_WB: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
`endif
         S_TRAP: begin
            o_ctrl.illegal    = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control
//  Purpose  : Multi-cycle main control FSM of the MIPS core. Sequences fetch,
//             decode, execute, memory and write-back over a shared datapath,
//             stalling on the memory-ready handshake.
//  Ports    : clk, reset (async, active-high), opcode[5:0], mem_ready
//             datapath enables/selects: pc_write, pc_write_cond, i_or_d,
//             mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
//             alu_src_a, alu_src_b[1:0], pc_source[1:0], alu_op[1:0]
//             status: instr_done, illegal, state[3:0]
//  Config   : MC_CONTROL_ADDI_EN adds the addi path (ADDI_EX -> ADDI_WB);
//             otherwise opcode 001000 traps like any unknown opcode.
//  Revision : 1.0  initial release
// ============================================================================
module mc_control
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [1:0] alu_op,
   output logic       instr_done,
   output logic       illegal,
   output logic [3:0] state
);

   state_t r_state;
   state_t w_next;
   ctrl_t  w_ctrl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_next = S_MEM_ADDR;
               OP_RTYPE:     w_next = S_EXEC;
               OP_BEQ:       w_next = S_BRANCH;
               OP_J:         w_next = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
               OP_ADDI:      w_next = S_ADDI_EX;
`endif
               default:      w_next = S_TRAP;
            endcase
         end
         // Only lw/sw reach this state, so anything not sw is a load
         S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   w_next = mem_ready ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
         S_EXEC:     w_next = S_WB_ALU;
`ifdef MC_CONTROL_ADDI_EN
         S_ADDI_EX:  w_next = S_ADDI_WB;
`endif
         // Final states and unused encodings all return to fetch
         default:    w_next = S_FETCH;
      endcase
   end

   mc_control_decode u_decode (
      .i_state     (r_state),
      .i_mem_ready (mem_ready),
      .o_ctrl      (w_ctrl)
   );

   assign pc_write      = w_ctrl.pc_write;
   assign pc_write_cond = w_ctrl.pc_write_cond;
   assign i_or_d        = w_ctrl.i_or_d;
   assign mem_read      = w_ctrl.mem_read;
   assign mem_write     = w_ctrl.mem_write;
   assign ir_write      = w_ctrl.ir_write;
   assign mem_to_reg    = w_ctrl.mem_to_reg;
   assign reg_dst       = w_ctrl.reg_dst;
   assign reg_write     = w_ctrl.reg_write;
   assign alu_src_a     = w_ctrl.alu_src_a;
   assign alu_src_b     = w_ctrl.alu_src_b;
   assign pc_source     = w_ctrl.pc_source;
   assign alu_op        = w_ctrl.alu_op;
   assign instr_done    = w_ctrl.instr_done;
   assign illegal       = w_ctrl.illegal;
   assign state         = r_state;

endmodule
`default_nettype wire

// File: doc/mc_control.md
# mc_control

Multi-cycle main control FSM for the MIPS core. It sequences the shared datapath (PC, memory, IR, register file, single ALU) through fetch, decode, execute, memory and write-back. It drives the 2-bit ALUOp consumed by the ALU control decoder, plus every mux select and write enable. It stalls on a memory-ready handshake and signals instruction completion for the bench and for the performance counters.

## Interface
- No parameters; state encoding and opcodes come from the shared package.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH
- opcode  in  6  IR[31:26]; valid from DECODE until instruction end
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write  out  1 each  datapath enables/selects
- mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each
- alu_src_b  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_op  out  2  00 add, 01 sub, 10 use funct
- instr_done  out  1  high in the final cycle of every instruction
- illegal  out  1  high for the single TRAP cycle
- state  out  4  current state (debug)

## Operation
- Moore FSM in a 4-bit state register. Outputs decode from state only, except where gated by mem_ready. Any output not listed for a state is 0.
- **FETCH (0)**
  - Outputs: mem_read=1, alu_src_b=01, alu_op=00, i_or_d=0, pc_source=00.
  - ir_write and pc_write = mem_ready.
  - Next: DECODE if mem_ready, else stay.
- **DECODE (1)**
  - Outputs: alu_src_b=11, alu_op=00 (branch target precompute).
  - Next by opcode: 100011/101011 → MEM_ADDR; 000000 → EXEC; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDI_EX (macro only); any other → TRAP.
- **MEM_ADDR (2)**
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: MEM_RD for lw, MEM_WR for sw.
- **MEM_RD (3)**
  - Outputs: mem_read=1, i_or_d=1.
  - Next: WB_MEM on mem_ready, else stay.
- **WB_MEM (4)**
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
  - Next: FETCH.
- **MEM_WR (5)**
  - Outputs: mem_write=1, i_or_d=1, instr_done=mem_ready.
  - Next: FETCH on mem_ready, else stay.
- **EXEC (6)**
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next: WB_ALU.
- **WB_ALU (7)**
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1.
  - Next: FETCH.
- **BRANCH (8)**
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
  - Next: FETCH.
- **JUMP (9)**
  - Outputs: pc_write=1, pc_source=10, instr_done=1.
  - Next: FETCH.
- **ADDI_EX (10)**
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: ADDI_WB.
- **ADDI_WB (11)**
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
  - Next: FETCH.
- **TRAP (12)**
  - Outputs: illegal=1, instr_done=1; no enables asserted.
  - Next: FETCH.
- Encodings 13–15 are unreachable. If entered, the FSM goes to FETCH next cycle with all outputs 0.
- Reset mid-instruction abandons the instruction; no partial write-back occurs after the reset edge.

## Timing
- Reset values (state = FETCH): mem_read=1, alu_src_b=01, state=0.
  - pc_write and ir_write follow mem_ready, even while reset is held.
  - All other outputs are 0.
- Cycle counts with zero wait (mem_ready tied high):
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 3.
- Each low cycle of mem_ready in FETCH, MEM_RD or MEM_WR adds exactly one cycle. All outputs hold stable during the wait.
- mem_ready is ignored in every other state.
- opcode is sampled only at the DECODE and MEM_ADDR edges.

## Configuration
- MC_CONTROL_ADDI_EN defined: opcode 001000 decodes to ADDI_EX → ADDI_WB.
- MC_CONTROL_ADDI_EN undefined: states 10/11 are absent, and 001000 goes to TRAP like any other unknown opcode.

## Structure
- mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - ALUOp codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - state localparams S_FETCH…S_TRAP;
  - alu_src_b and pc_source select codes.
- One sub-module, mc_control_decode: purely combinational state + mem_ready → control-word decode.
- The state register and next-state logic stay in mc_control.

## Test plan
- Reset high with mem_ready=0 → state=0, mem_read=1, pc_write=0, ir_write=0. Release reset, raise mem_ready → DECODE on the next edge.
- lw (100011), mem_ready low for 2 cycles in MEM_RD → states 0,1,2,3,3,3,4; instr_done in state 4 only; 7 cycles total.
- R-type then beq (000100), mem_ready=1 → alu_op 10 in EXEC and 01 in BRANCH; pc_write_cond=1 only in BRANCH; cycle counts 4 and 3.
- sw (101011) with one wait in MEM_WR → mem_write held for 2 cycles; instr_done only in the mem_ready=1 cycle; reg_write never asserted.
- Opcode 001000 → with MC_CONTROL_ADDI_EN: states 0,1,10,11, reg_write=1 in state 11. Without it: states 0,1,12, illegal=1 for one cycle.
- Assert reset while in MEM_RD → state=0 immediately (asynchronous); reg_write stays 0; the next fetch proceeds normally.
